// File: rtl/mc_main_control.sv
// Multicycle MIPS main control: Moore FSM sequencing the datapath one micro-step per clock.
// Memory steps stall on mem_ready; all outputs are forced low while reset_n is asserted.
module mc_main_control (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_RTEX   = 4'd6,
        ST_RTWB   = 4'd7,
        ST_BEQ    = 4'd8,
        ST_JUMP   = 4'd9,
        ST_ADDIEX = 4'd10,
        ST_ADDIWB = 4'd11
    } state_t;

    state_t r_state;
    state_t w_next;

    logic       w_is_lw;
    logic       w_is_sw;
    logic       w_is_rt;
    logic       w_is_beq;
    logic       w_is_j;
    logic       w_is_addi;

    logic       w_pcwrite;
    logic       w_pcwritecond;
    logic       w_iord;
    logic       w_memread;
    logic       w_memwrite;
    logic       w_memtoreg;
    logic       w_irwrite;
    logic [1:0] w_pcsource;
    logic [1:0] w_aluop;
    logic       w_alusrca;
    logic [1:0] w_alusrcb;
    logic       w_regwrite;
    logic       w_regdst;
    logic       w_illegal;

    assign w_is_lw   = (opcode == 6'b100011);
    assign w_is_sw   = (opcode == 6'b101011);
    assign w_is_rt   = (opcode == 6'b000000);
    assign w_is_beq  = (opcode == 6'b000100);
    assign w_is_j    = (opcode == 6'b000010);
    assign w_is_addi = (opcode == 6'b001000);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = ST_FETCH;
        w_pcwrite     = 1'b0;
        w_pcwritecond = 1'b0;
        w_iord        = 1'b0;
        w_memread     = 1'b0;
        w_memwrite    = 1'b0;
        w_memtoreg    = 1'b0;
        w_irwrite     = 1'b0;
        w_pcsource    = 2'b00;
        w_aluop       = 2'b00;
        w_alusrca     = 1'b0;
        w_alusrcb     = 2'b00;
        w_regwrite    = 1'b0;
        w_regdst      = 1'b0;
        w_illegal     = 1'b0;

        case (r_state)
            ST_FETCH: begin
                // PC+4 is computed every cycle, but only committed with the IR
                w_memread = 1'b1;
                w_alusrcb = 2'b01;
                w_irwrite = mem_ready;
                w_pcwrite = mem_ready;
                w_next    = mem_ready ? ST_DECODE : ST_FETCH;
            end
            ST_DECODE: begin
                w_alusrcb = 2'b11;
                unique case (1'b1)
                    w_is_lw,
                    w_is_sw:   w_next = ST_MEMADR;
                    w_is_rt:   w_next = ST_RTEX;
                    w_is_beq:  w_next = ST_BEQ;
                    w_is_j:    w_next = ST_JUMP;
                    w_is_addi: w_next = ST_ADDIEX;
                    default: begin
                        w_next    = ST_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            ST_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_next    = w_is_lw ? ST_MEMRD : ST_MEMWR;
            end
            ST_MEMRD: begin
                w_memread = 1'b1;
                w_iord    = 1'b1;
                w_next    = mem_ready ? ST_MEMWB : ST_MEMRD;
            end
            ST_MEMWB: begin
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
                w_next     = ST_FETCH;
            end
            ST_MEMWR: begin
                w_memwrite = 1'b1;
                w_iord     = 1'b1;
                w_next     = mem_ready ? ST_FETCH : ST_MEMWR;
            end
            ST_RTEX: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b10;
                w_next    = ST_RTWB;
            end
            ST_RTWB: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
                w_next     = ST_FETCH;
            end
            ST_BEQ: begin
                w_alusrca     = 1'b1;
                w_aluop       = 2'b01;
                w_pcwritecond = 1'b1;
                w_pcsource    = 2'b01;
                w_next        = ST_FETCH;
            end
            ST_JUMP: begin
                w_pcwrite  = 1'b1;
                w_pcsource = 2'b10;
                w_next     = ST_FETCH;
            end
            ST_ADDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_next    = ST_ADDIWB;
            end
            ST_ADDIWB: begin
                w_regwrite = 1'b1;
                w_next     = ST_FETCH;
            end
            default: begin
                w_next = ST_FETCH;
            end
        endcase
    end

    // Reset masks every output so no request leaks while the state is being cleared
    assign PCWrite     = reset_n & w_pcwrite;
    assign PCWriteCond = reset_n & w_pcwritecond;
    assign IorD        = reset_n & w_iord;
    assign MemRead     = reset_n & w_memread;
    assign MemWrite    = reset_n & w_memwrite;
    assign MemtoReg    = reset_n & w_memtoreg;
    assign IRWrite     = reset_n & w_irwrite;
    assign PCSource    = reset_n ? w_pcsource : 2'b00;
    assign ALUOp       = reset_n ? w_aluop : 2'b00;
    assign ALUSrcA     = reset_n & w_alusrca;
    assign ALUSrcB     = reset_n ? w_alusrcb : 2'b00;
    assign RegWrite    = reset_n & w_regwrite;
    assign RegDst      = reset_n & w_regdst;
    assign illegal     = reset_n & w_illegal;
    assign state       = reset_n ? r_state : 4'd0;

endmodule

// File: doc/mc_main_control.md
# mc_main_control

Multicycle main control unit for the MIPS datapath. A Moore-style state machine decodes the instruction opcode and sequences the datapath one micro-step per clock. It drives all datapath enables and muxes, and drives the 2-bit ALUOp consumed by the downstream ALU control stage. Memory accesses use a ready handshake so that a slow memory can stall the machine.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- opcode  in  6  instr[31:26] from the instruction register; stable from DECODE onward.
- mem_ready  in  1  memory completes the current read/write this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified by ALU zero (beq).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- MemtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR.
- IRWrite  out  1  instruction register load.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- ALUOp  out  2  00 = add, 01 = subtract, 10 = use funct field.
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- RegWrite  out  1  register file write.
- RegDst  out  1  destination register: 0 = rt, 1 = rd.
- illegal  out  1  one-cycle flag: unsupported opcode was decoded.
- state  out  4  current state encoding, for debug.

## Operation
State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEX 6, RTWB 7, BEQ 8, JUMP 9, ADDIEX 10, ADDIWB 11. Codes 12–15 are unreachable and must go to FETCH on the next edge.

Any output not listed for a state is 0.

- **FETCH:** MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite = PCWrite = mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- **DECODE:** ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute). Next state by opcode:
  - 100011 or 101011 → MEMADR
  - 000000 → RTEX
  - 000100 → BEQ
  - 000010 → JUMP
  - 001000 → ADDIEX
  - any other opcode → FETCH, with illegal=1 during this DECODE cycle only.
- **MEMADR:** ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state: MEMRD if opcode=100011, else MEMWR.
- **MEMRD:** MemRead=1, IorD=1. Holds until mem_ready=1, then → MEMWB.
- **MEMWB:** RegDst=0, MemtoReg=1, RegWrite=1. → FETCH.
- **MEMWR:** MemWrite=1, IorD=1. Holds until mem_ready=1, then → FETCH.
- **RTEX:** ALUSrcA=1, ALUSrcB=00, ALUOp=10. → RTWB.
- **RTWB:** RegDst=1, MemtoReg=0, RegWrite=1. → FETCH.
- **BEQ:** ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. → FETCH.
- **JUMP:** PCWrite=1, PCSource=10. → FETCH.
- **ADDIEX:** ALUSrcA=1, ALUSrcB=10, ALUOp=00. → ADDIWB.
- **ADDIWB:** RegDst=0, MemtoReg=0, RegWrite=1. → FETCH.

## Timing
- **Outputs:** decoded from the state register, plus mem_ready gating in FETCH and opcode gating of `illegal`. No output is registered separately.
- **Reset:** while reset_n=0, the state register is forced to FETCH and every output is forced to 0 (including MemRead and `state`). The first request appears in the cycle after reset_n rises. If reset_n is asserted mid-instruction, the machine aborts immediately with no further writes; pending memory handshakes are dropped.
- **Latency with mem_ready tied to 1:**
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
  - illegal opcode: 2 cycles
- **Stalls:** each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. The request outputs are held constant throughout the stall.
- **mem_ready outside those three states:** ignored.
- **Write strobes:** IRWrite and PCWrite in FETCH pulse only in the cycle mem_ready=1, so each is asserted exactly once per instruction.

## Test plan
- **Reset:** hold reset_n=0 for 3 cycles, then release with mem_ready=1. During reset all outputs are 0. First post-reset cycle: state=0, MemRead=1, ALUSrcB=01, IRWrite=1, PCWrite=1.
- **lw with memory stall:** opcode=100011, mem_ready=1 except 2 low cycles in MEMRD. State sequence 0,1,2,3,3,3,4,0. RegWrite=1 with MemtoReg=1 only in state 4.
- **R-type then beq:** opcode=000000 gives sequence 0,1,6,7,0 with ALUOp=10 in state 6 and RegDst=1 in state 7. Then opcode=000100 gives 0,1,8,0 with ALUOp=01, PCWriteCond=1, PCSource=01 in state 8.
- **sw, j, addi:** sw gives 0,1,2,5,0 with MemWrite=1, IorD=1 in state 5. j gives 0,1,9,0 with PCWrite=1, PCSource=10. addi gives 0,1,10,11,0 with ALUSrcB=10 then RegWrite=1, RegDst=0.
- **Illegal opcode:** opcode=111111 gives illegal=1 for exactly one cycle in state 1, next state 0, and no RegWrite, MemWrite or PCWrite beyond FETCH.
- **Reset mid-operation:** drop reset_n in MEMWR while mem_ready=0. MemWrite falls to 0 asynchronously, and after release the state is 0.
